// File: rtl/pwm_bank_pkg.sv
// Shared types, register offsets and defaults for the pwm_bank slice.
// Optional dead-time on mode changes is enabled with PWM_BANK_DEAD_TIME_EN.
package pwm_bank_pkg;

    localparam int NOS_PWM_CHANNELS = 4;

    localparam logic [1:0] PWM_REG_PERIOD  = 2'd0;
    localparam logic [1:0] PWM_REG_ON_TIME = 2'd1;
    localparam logic [1:0] PWM_REG_CONFIG  = 2'd2;
    localparam logic [1:0] PWM_REG_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        FWD   = 2'b01,
        REV   = 2'b10,
        BRAKE = 2'b11
    } h_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } ch_state_t;

    // Returns {leg1, leg2} for a bridge mode.
    function automatic logic [1:0] mode_legs(input h_mode_t m);
        logic [1:0] legs;
        case (m)
            FWD:     legs = 2'b10;
            REV:     legs = 2'b01;
            BRAKE:   legs = 2'b11;
            default: legs = 2'b00;
        endcase
        return legs;
    endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM / H-bridge channel: counter, staging/active registers and mode FSM.
// Dead-time on mode changes is built only with PWM_BANK_DEAD_TIME_EN defined.
module pwm_bank_channel
    import pwm_bank_pkg::*;
#(
    parameter int PWM_WIDTH   = 16,
    parameter int DEAD_CYCLES = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_sel,
    output logic [31:0] rd_word,
    output logic        pwm_out,
    output logic        h_bridge_1,
    output logic        h_bridge_2
);

    logic [PWM_WIDTH-1:0] period_stg;
    logic [PWM_WIDTH-1:0] on_time_stg;
    logic [PWM_WIDTH-1:0] period_act;
    logic [PWM_WIDTH-1:0] on_time_act;
    logic [PWM_WIDTH-1:0] counter;
    logic                 enable;
    h_mode_t              cfg_mode;
    h_mode_t              active_mode;
    ch_state_t            state;

    logic    wrap;
    logic    cfg_wr;
    logic    en_rise;
    logic    dead;
    logic    pwm_next;
    h_mode_t new_mode;
    h_mode_t drive_mode;

`ifdef PWM_BANK_DEAD_TIME_EN
    localparam int DCW = $clog2(DEAD_CYCLES + 1);
    logic [DCW-1:0] dead_cnt;
    h_mode_t        pending_mode;
`else
    logic unused_dead_cycles;
    assign unused_dead_cycles = ^DEAD_CYCLES;
`endif

    logic unused_wr_data;
    assign unused_wr_data = ^wr_data;

    // A zero period counts as a wrap every cycle so a new period can load.
    always_comb begin
        wrap       = (period_act == '0) || (counter == period_act - PWM_WIDTH'(1));
        cfg_wr     = wr_en && (wr_sel == PWM_REG_CONFIG);
        new_mode   = h_mode_t'(wr_data[2:1]);
        en_rise    = cfg_wr && wr_data[0] && !enable;
        dead       = (state == ST_DEAD);
        pwm_next   = enable && (period_act != '0) && (counter < on_time_act) && !dead;
        drive_mode = (!enable || dead) ? COAST : active_mode;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_stg  <= '0;
            on_time_stg <= '0;
            period_act  <= '0;
            on_time_act <= '0;
            counter     <= '0;
            enable      <= 1'b0;
            cfg_mode    <= COAST;
            active_mode <= COAST;
            state       <= ST_IDLE;
            pwm_out     <= 1'b0;
            h_bridge_1  <= 1'b0;
            h_bridge_2  <= 1'b0;
`ifdef PWM_BANK_DEAD_TIME_EN
            dead_cnt     <= '0;
            pending_mode <= COAST;
`endif
        end else begin
            if (wr_en) begin
                case (wr_sel)
                    PWM_REG_PERIOD:  period_stg  <= wr_data[PWM_WIDTH-1:0];
                    PWM_REG_ON_TIME: on_time_stg <= wr_data[PWM_WIDTH-1:0];
                    PWM_REG_CONFIG: begin
                        enable   <= wr_data[0];
                        cfg_mode <= new_mode;
                    end
                    default: ;
                endcase
            end

            // Loads see the staging value from before any same-cycle write.
            if (!enable || wrap) begin
                period_act  <= period_stg;
                on_time_act <= on_time_stg;
            end

            if (en_rise || wrap)
                counter <= '0;
            else
                counter <= counter + PWM_WIDTH'(1);

`ifdef PWM_BANK_DEAD_TIME_EN
            if (cfg_wr && (new_mode != active_mode)) begin
                state        <= ST_DEAD;
                pending_mode <= new_mode;
                dead_cnt     <= '0;
            end else if (state == ST_DEAD) begin
                if (dead_cnt == DCW'(DEAD_CYCLES - 1)) begin
                    state       <= ST_RUN;
                    active_mode <= pending_mode;
                end else begin
                    dead_cnt <= dead_cnt + DCW'(1);
                end
            end
`else
            if (cfg_wr) begin
                state       <= ST_RUN;
                active_mode <= new_mode;
            end
`endif

            pwm_out                  <= pwm_next;
            {h_bridge_1, h_bridge_2} <= mode_legs(drive_mode);
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd_sel)
            PWM_REG_PERIOD:  rd_word[PWM_WIDTH-1:0] = period_stg;
            PWM_REG_ON_TIME: rd_word[PWM_WIDTH-1:0] = on_time_stg;
            PWM_REG_CONFIG:  rd_word[2:0]           = {cfg_mode, enable};
            default: begin
                rd_word[PWM_WIDTH-1:0] = counter;
                rd_word[16]            = pwm_out;
                rd_word[17]            = dead;
                rd_word[19:18]         = active_mode;
            end
        endcase
    end

endmodule

// File: rtl/pwm_bank.sv
// Register-mapped bank of NOS_CH PWM / H-bridge channels with address decode.
// Define PWM_BANK_DEAD_TIME_EN to insert dead-time on bridge mode changes.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int         NOS_CH      = NOS_PWM_CHANNELS,
    parameter int         PWM_WIDTH   = 16,
    parameter logic [7:0] REG_BASE    = 8'h20,
    parameter int         DEAD_CYCLES = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [7:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              reg_ack,
    output logic [NOS_CH-1:0] pwm_out,
    output logic [NOS_CH-1:0] H_bridge_1,
    output logic [NOS_CH-1:0] H_bridge_2
);

    logic [8:0]        offset;
    logic              hit;
    logic [3:0]        ch_idx;
    logic [1:0]        reg_sel;
    logic [NOS_CH-1:0] ch_wr;
    logic [31:0]       rd_words [NOS_CH];
    logic [31:0]       sel_word;

    // Nine-bit offset keeps addresses below REG_BASE from aliasing into range.
    always_comb begin
        offset  = {1'b0, reg_addr} - {1'b0, REG_BASE};
        hit     = (reg_addr >= REG_BASE) && (offset < 9'(4 * NOS_CH));
        ch_idx  = offset[5:2];
        reg_sel = offset[1:0];
    end

    always_comb begin
        ch_wr    = '0;
        sel_word = '0;
        for (int unsigned i = 0; i < NOS_CH; i++) begin
            if ({28'd0, ch_idx} == i) begin
                ch_wr[i] = hit && reg_wr;
                sel_word = rd_words[i];
            end
        end
    end

    for (genvar i = 0; i < NOS_CH; i++) begin : g_ch
        pwm_bank_channel #(
            .PWM_WIDTH  (PWM_WIDTH),
            .DEAD_CYCLES(DEAD_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_en     (ch_wr[i]),
            .wr_sel    (reg_sel),
            .wr_data   (reg_wdata),
            .rd_sel    (reg_sel),
            .rd_word   (rd_words[i]),
            .pwm_out   (pwm_out[i]),
            .h_bridge_1(H_bridge_1[i]),
            .h_bridge_2(H_bridge_2[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ack   <= hit && (reg_wr || reg_rd);
            reg_rdata <= (hit && reg_rd && !reg_wr) ? sel_word : '0;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: cycle model of the register/PWM rules plus directed checks.
`timescale 1ns/1ps
module tb_pwm_bank;

    localparam int         NCH  = 4;
    localparam int         DC   = 50;
    localparam logic [7:0] BASE = 8'h20;
`ifdef PWM_BANK_DEAD_TIME_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           reg_wr = 1'b0;
    logic           reg_rd = 1'b0;
    logic [7:0]     reg_addr = '0;
    logic [31:0]    reg_wdata = '0;
    logic [31:0]    reg_rdata;
    logic           reg_ack;
    logic [NCH-1:0] pwm_out, H_bridge_1, H_bridge_2;

    pwm_bank #(
        .NOS_CH     (NCH),
        .PWM_WIDTH  (16),
        .REG_BASE   (BASE),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .pwm_out   (pwm_out),
        .H_bridge_1(H_bridge_1),
        .H_bridge_2(H_bridge_2)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_sp[NCH], m_so[NCH], m_ap[NCH], m_ao[NCH], m_cnt[NCH];
    int m_en[NCH], m_cm[NCH], m_am[NCH], m_pend[NCH], m_dl[NCH];
    logic [NCH-1:0] e_pwm, e_h1, e_h2, n_pwm, n_h1, n_h2;
    logic           e_ack;
    logic [31:0]    e_rdata;
    bit             live = 1'b0;
    int             off, csel, ksel, eff, nm;
    bit             hit, wrap, wsel, cfgw;

    function automatic int m_word(input int c, input int k);
        case (k)
            0: return m_sp[c];
            1: return m_so[c];
            2: return (m_cm[c] << 1) | m_en[c];
            default: return m_cnt[c] | (int'(e_pwm[c]) << 16) |
                            ((m_dl[c] > 0 ? 1 : 0) << 17) | (m_am[c] << 18);
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_sp[c] = 0; m_so[c] = 0; m_ap[c] = 0; m_ao[c] = 0; m_cnt[c] = 0;
                m_en[c] = 0; m_cm[c] = 0; m_am[c] = 0; m_pend[c] = 0; m_dl[c] = 0;
            end
            e_pwm = '0; e_h1 = '0; e_h2 = '0; e_ack = 1'b0; e_rdata = '0;
            live = 1'b1;
        end else begin
            off  = int'(reg_addr) - int'(BASE);
            hit  = (off >= 0) && (off < 4 * NCH);
            csel = hit ? off / 4 : 0;
            ksel = hit ? off % 4 : 0;
            nm   = int'(reg_wdata[2:1]);
            e_ack   = hit && (reg_wr || reg_rd);
            e_rdata = (hit && reg_rd && !reg_wr) ? 32'(m_word(csel, ksel)) : 32'd0;
            for (int c = 0; c < NCH; c++) begin
                n_pwm[c] = (m_en[c] != 0) && (m_ap[c] != 0) && (m_cnt[c] < m_ao[c]) && (m_dl[c] == 0);
                eff      = (m_en[c] == 0 || m_dl[c] > 0) ? 0 : m_am[c];
                n_h1[c]  = (eff == 1) || (eff == 3);
                n_h2[c]  = (eff == 2) || (eff == 3);
                wrap = (m_ap[c] == 0) || (m_cnt[c] == m_ap[c] - 1);
                wsel = reg_wr && hit && (csel == c);
                cfgw = wsel && (ksel == 2);
                if (cfgw && reg_wdata[0] && m_en[c] == 0) m_cnt[c] = 0;
                else if (wrap)                            m_cnt[c] = 0;
                else                                      m_cnt[c] = (m_cnt[c] + 1) % 65536;
                if (m_en[c] == 0 || wrap) begin
                    m_ap[c] = m_sp[c];
                    m_ao[c] = m_so[c];
                end
                if (DT) begin
                    if (cfgw && nm != m_am[c]) begin
                        m_pend[c] = nm;
                        m_dl[c]   = DC;
                    end else if (m_dl[c] > 0) begin
                        m_dl[c]--;
                        if (m_dl[c] == 0) m_am[c] = m_pend[c];
                    end
                end else if (cfgw) begin
                    m_am[c] = nm;
                end
                if (wsel) begin
                    case (ksel)
                        0: m_sp[c] = int'(reg_wdata[15:0]);
                        1: m_so[c] = int'(reg_wdata[15:0]);
                        2: begin m_en[c] = int'(reg_wdata[0]); m_cm[c] = nm; end
                        default: ;
                    endcase
                end
            end
            e_pwm = n_pwm; e_h1 = n_h1; e_h2 = n_h2;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("cyc_pwm_out",    32'(pwm_out),    32'(e_pwm));
            check("cyc_H_bridge_1", 32'(H_bridge_1), 32'(e_h1));
            check("cyc_H_bridge_2", 32'(H_bridge_2), 32'(e_h2));
            check("cyc_reg_ack",    32'(reg_ack),    32'(e_ack));
            check("cyc_reg_rdata",  reg_rdata,       e_rdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clk);
        check("wr_ack", 32'(reg_ack), 32'd1);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic ack);
        @(negedge clk);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge clk);
        d = reg_rdata; ack = reg_ack;
        reg_rd = 1'b0;
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pwm_out[ch]) hi++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic        a;
        int          hi, zeros;
        bit          done;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_h1",  32'(H_bridge_1), 32'd0);
        rd(8'h20, v, a);
        check("reset_rd_period", v, 32'd0);

        // basic PWM on ch0: 10 period, 3 on, forward
        wr(8'h20, 32'd10);
        wr(8'h21, 32'd3);
        wr(8'h22, 32'h3);
        repeat (60) @(negedge clk);
        count_high(0, 10, hi);
        check("basic_duty", 32'(hi), 32'd3);
        check("basic_h1", 32'(H_bridge_1[0]), 32'd1);
        check("basic_h2", 32'(H_bridge_2[0]), 32'd0);

        // boundary updates
        wr(8'h21, 32'd7);
        repeat (20) @(negedge clk);
        count_high(0, 10, hi);
        check("duty_7", 32'(hi), 32'd7);
        wr(8'h21, 32'd12);
        repeat (20) @(negedge clk);
        count_high(0, 10, hi);
        check("duty_full", 32'(hi), 32'd10);
        wr(8'h20, 32'd0);
        repeat (20) @(negedge clk);
        count_high(0, 10, hi);
        check("period0_low", 32'(hi), 32'd0);
        rd(8'h23, v, a);
        check("period0_cnt", 32'(v[15:0]), 32'd0);
        wr(8'h20, 32'd10);
        wr(8'h21, 32'd3);

        // isolation, readback, unused bits, address range, combined strobes
        wr(8'h2C, 32'd5);
        wr(8'h2D, 32'd2);
        wr(8'h2E, 32'hABCD_0005);
        rd(8'h2E, v, a);
        check("cfg_unused_bits", v, 32'd5);
        wr(8'h24, 32'd8);
        wr(8'h25, 32'd4);
        wr(8'h26, 32'h7);
        rd(8'h24, v, a);
        check("ch1_period_rd", v, 32'd8);
        repeat (60) @(negedge clk);
        rd(8'h23, v, a);
        rd(8'h23, v, a);
        rd(8'h30, v, a);
        check("oor_high_ack", 32'(a), 32'd0);
        rd(8'h1F, v, a);
        check("oor_low_ack", 32'(a), 32'd0);
        @(negedge clk);
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = 8'h21; reg_wdata = 32'd3;
        @(negedge clk);
        check("wr_rd_rdata", reg_rdata, 32'd0);
        reg_wr = 1'b0; reg_rd = 1'b0;
        repeat (12) @(negedge clk);

`ifdef PWM_BANK_DEAD_TIME_EN
        wr(8'h28, 32'd10);
        wr(8'h29, 32'd5);
        wr(8'h2A, 32'h3);
        repeat (60) @(negedge clk);
        wr(8'h2A, 32'h5);
        zeros = 0; done = 1'b0;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            if (n == 5) begin reg_rd = 1'b1; reg_addr = 8'h2B; end
            if (n == 6) begin
                reg_rd = 1'b0;
                check("dead_status_bit17", 32'(reg_rdata[17]), 32'd1);
            end
            if (H_bridge_2[2]) done = 1'b1;
            else if (!H_bridge_1[2] && !pwm_out[2]) zeros++;
        end
        check("dead_done", 32'(done), 32'd1);
        check("dead_len", 32'(zeros), 32'd50);

        repeat (10) @(negedge clk);
        wr(8'h2A, 32'h3);
        zeros = 0; done = 1'b0;
        for (int n = 1; n <= 300 && !done; n++) begin
            @(negedge clk);
            if (n == 19) begin reg_wr = 1'b1; reg_addr = 8'h2A; reg_wdata = 32'h7; end
            if (n == 20) reg_wr = 1'b0;
            if (H_bridge_1[2] && H_bridge_2[2]) done = 1'b1;
            else if (!H_bridge_1[2] && !H_bridge_2[2] && !pwm_out[2]) zeros++;
        end
        check("dead_ext_done", 32'(done), 32'd1);
        check("dead_ext_len", 32'(zeros), 32'd70);
        wr(8'h2A, 32'h1);
`endif

        // reset while ch0 PWM is high (and ch2 mid dead-time when enabled)
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (pwm_out[0]) done = 1'b1;
        end
        check("wait_pwm_high", 32'(done), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_pwm", 32'(pwm_out), 32'd0);
        check("rst_mid_h1", 32'(H_bridge_1), 32'd0);
        check("rst_mid_h2", 32'(H_bridge_2), 32'd0);
        reset = 1'b0;
        rd(8'h20, v, a);
        check("rst_rd_period", v, 32'd0);
        rd(8'h2B, v, a);
        check("rst_rd_status", v, 32'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
